// File: rtl/gobou_seq.sv
// gobou_seq: FC-layer sequencer for the gobou core; each neuron takes 1+N+RD_LAT+MAC_LAT+4 cycles.
// No backpressure: a rising edge on req starts a layer only while idle (ack=1); later edges are ignored.
module gobou_seq #(
  parameter int LWIDTH  = 12,
  parameter int IADDR   = 12,
  parameter int WADDR   = 16,
  parameter int OADDR   = 12,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              xrst,
  input  logic              req,
  input  logic [LWIDTH-1:0] total_in,
  input  logic [LWIDTH-1:0] total_out,
  input  logic [WADDR-1:0]  w_base,
  output logic              ack,
  output logic [IADDR-1:0]  input_addr,
  output logic [WADDR-1:0]  weight_addr,
  output logic [OADDR-1:0]  output_addr,
  output logic              output_we,
  output logic              accum_rst,
  output logic              accum_we,
  output logic              mac_oe,
  output logic              breg_we,
  output logic              bias_oe,
  output logic              relu_oe
);
  typedef enum logic [2:0] {IDLE, BIAS, ACC, DRAIN, OUT} state_t;

  // Last DRAIN cycle: mac_oe registered here lands MAC_LAT cycles after the final accumulate.
  localparam logic [3:0] DRAIN_LAST = 4'(RD_LAT + MAC_LAT - 1);

  state_t              state_q, state_d;
  logic [LWIDTH-1:0]   n_q, n_d, m_q, m_d, j_q, j_d, i_q, i_d;
  logic [WADDR-1:0]    nb_q, nb_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                req_q, start;
  logic [RD_LAT-1:0]   bias_dl_q, bias_dl_d, acc_dl_q, acc_dl_d;
  logic                bias_iss, acc_iss;
  logic                ack_q, ack_d;
  logic [IADDR-1:0]    input_addr_q, input_addr_d;
  logic [WADDR-1:0]    weight_addr_q, weight_addr_d;
  logic [OADDR-1:0]    output_addr_q, output_addr_d;
  logic                output_we_q, output_we_d;
  logic                bias_pulse_q, bias_pulse_d;
  logic                accum_we_q, accum_we_d;
  logic                mac_oe_q, mac_oe_d, bias_oe_q, bias_oe_d, relu_oe_q, relu_oe_d;

  assign start = req & ~req_q;

  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    m_d           = m_q;
    nb_d          = nb_q;
    j_d           = j_q;
    i_d           = i_q;
    cnt_d         = cnt_q;
    ack_d         = 1'b0;
    input_addr_d  = input_addr_q;
    weight_addr_d = weight_addr_q;
    output_addr_d = output_addr_q;
    output_we_d   = 1'b0;
    mac_oe_d      = 1'b0;
    bias_oe_d     = 1'b0;
    relu_oe_d     = 1'b0;
    bias_iss      = 1'b0;
    acc_iss       = 1'b0;

    case (state_q)
      IDLE: begin
        ack_d = 1'b1;
        if (start) begin
          n_d     = total_in;
          m_d     = total_out;
          nb_d    = w_base;
          j_d     = '0;
          ack_d   = 1'b0;
          state_d = (total_out == '0) ? IDLE : BIAS;
        end
      end
      BIAS: begin
        weight_addr_d = nb_q;
        bias_iss      = 1'b1;
        i_d           = '0;
        cnt_d         = '0;
        state_d       = (n_q == '0) ? DRAIN : ACC;
      end
      ACC: begin
        input_addr_d  = IADDR'(i_q);
        weight_addr_d = nb_q + WADDR'(i_q) + WADDR'(1);
        acc_iss       = 1'b1;
        i_d           = i_q + LWIDTH'(1);
        if (i_q == n_q - LWIDTH'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == DRAIN_LAST) begin
          mac_oe_d = 1'b1;
          cnt_d    = '0;
          state_d  = OUT;
        end
      end
      OUT: begin
        cnt_d = cnt_q + 4'd1;
        case (cnt_q)
          4'd0: bias_oe_d = 1'b1;
          4'd1: relu_oe_d = 1'b1;
          4'd2: begin
            output_we_d   = 1'b1;
            output_addr_d = OADDR'(j_q);
          end
          default: begin
            cnt_d = cnt_q;
            if ((bias_dl_q == '0) && (acc_dl_q == '0)) begin
              cnt_d = '0;
              j_d   = j_q + LWIDTH'(1);
              nb_d  = nb_q + WADDR'(n_q) + WADDR'(1);
              if (j_q == m_q - LWIDTH'(1)) begin
                state_d = IDLE;
                ack_d   = 1'b1;
              end else begin
                state_d = BIAS;
              end
            end
          end
        endcase
      end
      default: state_d = IDLE;
    endcase

    // Pulses ride behind their address by RD_LAT cycles so they meet the data on the buses.
    bias_dl_d    = (bias_dl_q << 1) | RD_LAT'(bias_iss);
    acc_dl_d     = (acc_dl_q << 1) | RD_LAT'(acc_iss);
    bias_pulse_d = bias_dl_q[RD_LAT-1];
    accum_we_d   = acc_dl_q[RD_LAT-1];
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q       <= IDLE;
      n_q           <= '0;
      m_q           <= '0;
      nb_q          <= '0;
      j_q           <= '0;
      i_q           <= '0;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      bias_dl_q     <= '0;
      acc_dl_q      <= '0;
      ack_q         <= 1'b1;
      input_addr_q  <= '0;
      weight_addr_q <= '0;
      output_addr_q <= '0;
      output_we_q   <= 1'b0;
      bias_pulse_q  <= 1'b0;
      accum_we_q    <= 1'b0;
      mac_oe_q      <= 1'b0;
      bias_oe_q     <= 1'b0;
      relu_oe_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      m_q           <= m_d;
      nb_q          <= nb_d;
      j_q           <= j_d;
      i_q           <= i_d;
      cnt_q         <= cnt_d;
      req_q         <= req;
      bias_dl_q     <= bias_dl_d;
      acc_dl_q      <= acc_dl_d;
      ack_q         <= ack_d;
      input_addr_q  <= input_addr_d;
      weight_addr_q <= weight_addr_d;
      output_addr_q <= output_addr_d;
      output_we_q   <= output_we_d;
      bias_pulse_q  <= bias_pulse_d;
      accum_we_q    <= accum_we_d;
      mac_oe_q      <= mac_oe_d;
      bias_oe_q     <= bias_oe_d;
      relu_oe_q     <= relu_oe_d;
    end
  end

  assign ack         = ack_q;
  assign input_addr  = input_addr_q;
  assign weight_addr = weight_addr_q;
  assign output_addr = output_addr_q;
  assign output_we   = output_we_q;
  assign accum_rst   = bias_pulse_q;
  assign breg_we     = bias_pulse_q;
  assign accum_we    = accum_we_q;
  assign mac_oe      = mac_oe_q;
  assign bias_oe     = bias_oe_q;
  assign relu_oe     = relu_oe_q;
endmodule

// File: tb/tb_gobou_seq.sv
// Bench for gobou_seq: per-cycle timeline model of a layer plus a behavioural gobou core fed from bench memories.
module tb_gobou_seq;
  localparam int RD  = 2;
  localparam int MAC = 3;

  logic        clk;
  logic        xrst;
  logic        req;
  logic [11:0] total_in, total_out;
  logic [15:0] w_base;
  logic        ack, output_we, accum_rst, accum_we, mac_oe, breg_we, bias_oe, relu_oe;
  logic [11:0] input_addr;
  logic [15:0] weight_addr;
  logic [11:0] output_addr;
  logic [7:0]  obs;

  int total = 0;
  int bad   = 0;

  int in_mem [0:4095];
  int w_mem  [0:65535];
  int out_mem[0:15];
  int wr_cnt = 0;
  logic [11:0] ia_h[RD];
  logic [15:0] wa_h[RD];
  int acc_m = 0, breg_m = 0, sum_m = 0, v_m = 0, r_m = 0;
  int px, wt;

  gobou_seq #(.LWIDTH(12), .IADDR(12), .WADDR(16), .OADDR(12), .RD_LAT(RD), .MAC_LAT(MAC)) dut (
    .clk(clk), .xrst(xrst), .req(req), .total_in(total_in), .total_out(total_out), .w_base(w_base),
    .ack(ack), .input_addr(input_addr), .weight_addr(weight_addr), .output_addr(output_addr),
    .output_we(output_we), .accum_rst(accum_rst), .accum_we(accum_we), .mac_oe(mac_oe),
    .breg_we(breg_we), .bias_oe(bias_oe), .relu_oe(relu_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {ack, breg_we, accum_rst, accum_we, mac_oe, bias_oe, relu_oe, output_we};

  // Memory data arrives RD cycles after its address was on the bus.
  always_comb begin
    px = in_mem[ia_h[RD-1]];
    wt = w_mem[wa_h[RD-1]];
  end

  always @(negedge clk) begin
    ia_h[0] <= input_addr;
    wa_h[0] <= weight_addr;
    for (int i = 1; i < RD; i++) begin
      ia_h[i] <= ia_h[i-1];
      wa_h[i] <= wa_h[i-1];
    end
    if (accum_rst) acc_m <= 0;
    else if (accum_we) acc_m <= acc_m + px * wt;
    if (breg_we) breg_m <= wt;
    if (mac_oe) sum_m <= acc_m;
    if (bias_oe) v_m <= sum_m + breg_m;
    if (relu_oe) r_m <= (v_m < 0) ? 0 : v_m;
    if (output_we) begin
      out_mem[output_addr[3:0]] <= r_m;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Expected {ack,breg_we,accum_rst,accum_we,mac_oe,bias_oe,relu_oe,output_we} k cycles after the start edge.
  function automatic logic [7:0] exp_strobes(input int k, input int n, input int m);
    int p, o, t;
    logic [7:0] e;
    p = 1 + n + RD + MAC + 4;
    if (k >= m * p) return 8'b1000_0000;
    o = k % p;
    t = 1 + n + RD + MAC;
    e = '0;
    e[6] = (o == 1 + RD);
    e[5] = (o == 1 + RD);
    e[4] = (o >= 2 + RD) && (o < 2 + RD + n);
    e[3] = (o == t);
    e[2] = (o == t + 1);
    e[1] = (o == t + 2);
    e[0] = (o == t + 3);
    return e;
  endfunction

  task automatic test_reset();
    int cnt;
    xrst = 1'b0; req = 1'b0; total_in = '0; total_out = '0; w_base = '0;
    repeat (3) @(negedge clk);
    total++;
    if (obs !== 8'b1000_0000) begin bad++; $display("FAIL reset_strobes got=%b want=%b", obs, 8'b1000_0000); end
    total++;
    if ({input_addr, weight_addr, output_addr} !== 40'd0)
      begin bad++; $display("FAIL reset_addr got=%h/%h/%h want=0", input_addr, weight_addr, output_addr); end
    xrst = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (obs !== 8'b1000_0000) cnt++;
    end
    total++;
    if (cnt != 0) begin bad++; $display("FAIL idle_quiet got=%0d busy cycles want=0", cnt); end
  endtask

  task automatic test_layer(input int n, input int m, input logic [15:0] base, input string name);
    int p, lo, awe, owe, j, off;
    logic [7:0]  e;
    logic [15:0] ew;
    p = 1 + n + RD + MAC + 4;
    lo = 0; awe = 0; owe = 0;
    total_in = 12'(n); total_out = 12'(m); w_base = base; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int k = 0; k < m * p + 3; k++) begin
      if (k > 0) @(negedge clk);
      e = exp_strobes(k, n, m);
      total++;
      if (obs !== e) begin bad++; $display("FAIL %s strobes k=%0d got=%b want=%b", name, k, obs, e); end
      j = k / p; off = k % p;
      if (k < m * p && off >= 1 && off <= 1 + n) begin
        ew = base + 16'(j * (n + 1) + off - 1);
        total++;
        if (weight_addr !== ew) begin bad++; $display("FAIL %s weight_addr k=%0d got=%0d want=%0d", name, k, weight_addr, ew); end
      end
      if (k < m * p && off >= 2 && off <= 1 + n) begin
        total++;
        if (input_addr !== 12'(off - 2)) begin bad++; $display("FAIL %s input_addr k=%0d got=%0d want=%0d", name, k, input_addr, off - 2); end
      end
      if (k < m * p && off == p - 1) begin
        total++;
        if (output_addr !== 12'(j)) begin bad++; $display("FAIL %s output_addr k=%0d got=%0d want=%0d", name, k, output_addr, j); end
      end
      if (k == m * p) begin
        ew = base + 16'((m - 1) * (n + 1) + n);
        total++;
        if (weight_addr !== ew) begin bad++; $display("FAIL %s weight_hold got=%0d want=%0d", name, weight_addr, ew); end
      end
      if (!ack) lo++;
      if (accum_we) awe++;
      if (output_we) owe++;
    end
    total++;
    if (lo != m * p) begin bad++; $display("FAIL %s ack_low got=%0d want=%0d", name, lo, m * p); end
    total++;
    if (awe != n * m || owe != m)
      begin bad++; $display("FAIL %s counts got awe=%0d owe=%0d want awe=%0d owe=%0d", name, awe, owe, n * m, m); end
  endtask

  task automatic test_core_e2e();
    int w0;
    in_mem[0] = 2; in_mem[1] = -3;
    w_mem[40] = 1;   w_mem[41] = 4; w_mem[42] = 1;
    w_mem[43] = -10; w_mem[44] = 4; w_mem[45] = 1;
    w0 = wr_cnt;
    test_layer(2, 2, 16'd40, "core");
    total++;
    if (out_mem[0] != 6) begin bad++; $display("FAIL core_value got=%0d want=6", out_mem[0]); end
    total++;
    if (out_mem[1] != 0 || wr_cnt - w0 != 2)
      begin bad++; $display("FAIL core_relu got=%0d writes=%0d want=0 writes=2", out_mem[1], wr_cnt - w0); end
  endtask

  task automatic test_n0();
    w_mem[200] = 7;
    test_layer(0, 1, 16'd200, "n0");
    total++;
    if (out_mem[0] != 7) begin bad++; $display("FAIL n0_value got=%0d want=7", out_mem[0]); end
  endtask

  task automatic test_m0();
    int cnt;
    total_in = 12'd2; total_out = 12'd0; w_base = 16'd5; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    total++;
    if (obs !== 8'b0000_0000) begin bad++; $display("FAIL m0_first got=%b want=%b", obs, 8'b0); end
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (obs !== 8'b1000_0000) cnt++;
    end
    total++;
    if (cnt != 0) begin bad++; $display("FAIL m0_after got=%0d bad cycles want=0", cnt); end
  endtask

  task automatic test_req_busy();
    int p, lo;
    logic [7:0] e;
    p = 1 + 2 + RD + MAC + 4;
    lo = 0;
    total_in = 12'd2; total_out = 12'd2; w_base = 16'd300; req = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2 * p + 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 3) total_in = 12'd7;
      if (k == p + 2) req = 1'b0;
      if (k == p + 3) req = 1'b1;
      e = exp_strobes(k, 2, 2);
      total++;
      if (obs !== e) begin bad++; $display("FAIL busy strobes k=%0d got=%b want=%b", k, obs, e); end
      if (!ack) lo++;
    end
    total++;
    if (lo != 2 * p || ack !== 1'b1) begin bad++; $display("FAIL busy_ack low=%0d ack=%b want low=%0d ack=1", lo, ack, 2 * p); end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int p, owe, lo;
    p = 1 + 4 + RD + MAC + 4;
    total_in = 12'd4; total_out = 12'd3; w_base = 16'd500; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (p + 3) @(negedge clk);
    #2 xrst = 1'b0;
    #1;
    total++;
    if (obs !== 8'b1000_0000 || {input_addr, weight_addr, output_addr} !== 40'd0)
      begin bad++; $display("FAIL midrst_outputs got=%b addr=%h/%h/%h want=%b addr=0", obs, input_addr, weight_addr, output_addr, 8'b1000_0000); end
    repeat (2) @(negedge clk);
    xrst = 1'b1;
    owe = 0; lo = 0;
    repeat (40) begin
      @(negedge clk);
      if (output_we) owe++;
      if (!ack) lo++;
    end
    total++;
    if (owe != 0 || lo != 0) begin bad++; $display("FAIL midrst_quiet got owe=%0d low=%0d want 0/0", owe, lo); end
    test_layer(1, 2, 16'd16, "after_rst");
  endtask

  task automatic test_random();
    int n, m;
    logic [15:0] base;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(0, 6);
      m = $urandom_range(1, 3);
      base = (it == 0) ? 16'hFFFD : 16'($urandom);
      test_layer(n, m, base, "rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_layer(3, 2, 16'd100, "n3m2");
    test_core_e2e();
    test_n0();
    test_m0();
    test_req_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
